// File: rtl/cdb_arbiter.sv
// Completion/writeback arbiter: one holding slot per FU, up to CDB_W slots
// broadcast per cycle in rotating-priority order with registered CDB outputs.
module cdb_arbiter #(
  parameter int NUM_FU = 8,
  parameter int CDB_W  = 3,
  parameter int PR_W   = 6,
  parameter int ROB_W  = 5,
  parameter int XLEN   = 32
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    squash_i,
  input  logic [NUM_FU-1:0]       fu_valid_i,
  input  logic [NUM_FU*PR_W-1:0]  fu_dest_pr_i,
  input  logic [NUM_FU*XLEN-1:0]  fu_value_i,
  input  logic [NUM_FU*ROB_W-1:0] fu_rob_entry_i,
  input  logic [NUM_FU-1:0]       fu_take_branch_i,
  input  logic [NUM_FU*XLEN-1:0]  fu_target_pc_i,
  output logic [NUM_FU-1:0]       fu_ready_o,
  output logic [CDB_W-1:0]        cdb_valid_o,
  output logic [CDB_W*PR_W-1:0]   cdb_pr_o,
  output logic [CDB_W*XLEN-1:0]   cdb_value_o,
  output logic [CDB_W*ROB_W-1:0]  complete_entry_o,
  output logic [CDB_W-1:0]        precise_state_valid_o,
  output logic [CDB_W*XLEN-1:0]   target_pc_o
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int CNT_W = $clog2(CDB_W + 1);

  logic             slot_valid_q [NUM_FU];
  logic [PR_W-1:0]  slot_pr_q    [NUM_FU];
  logic [XLEN-1:0]  slot_value_q [NUM_FU];
  logic [ROB_W-1:0] slot_rob_q   [NUM_FU];
  logic             slot_br_q    [NUM_FU];
  logic [XLEN-1:0]  slot_tgt_q   [NUM_FU];

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [NUM_FU-1:0] grant;
  logic [NUM_FU-1:0] accept;
  logic [CDB_W-1:0]  lane_act;
  logic [PTR_W-1:0]  lane_sel [CDB_W];

  logic             cdb_valid_q [CDB_W];
  logic [PR_W-1:0]  cdb_pr_q    [CDB_W];
  logic [XLEN-1:0]  cdb_value_q [CDB_W];
  logic [ROB_W-1:0] cdb_rob_q   [CDB_W];
  logic             cdb_psv_q   [CDB_W];
  logic [XLEN-1:0]  cdb_tgt_q   [CDB_W];

  // Circular scan from ptr; the k-th valid slot found drives lane k.
  always_comb begin
    logic [CNT_W-1:0] cnt;
    logic [PTR_W-1:0] idx;
    grant    = '0;
    lane_act = '0;
    ptr_d    = ptr_q;
    cnt      = '0;
    idx      = '0;
    for (int l = 0; l < CDB_W; l++) lane_sel[l] = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = PTR_W'((int'(ptr_q) + k) % NUM_FU);
      if (slot_valid_q[idx] && (cnt < CNT_W'(CDB_W))) begin
        grant[idx]    = 1'b1;
        lane_sel[cnt] = idx;
        lane_act[cnt] = 1'b1;
        ptr_d         = PTR_W'((int'(idx) + 1) % NUM_FU);
        cnt           = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i || squash_i) ptr_q <= '0;
    else                     ptr_q <= ptr_d;
  end

  genvar gi;

  // A granted slot frees up this cycle, so its FU may refill it at the same edge.
  for (gi = 0; gi < NUM_FU; gi++) begin : g_slot
    assign fu_ready_o[gi] = ~slot_valid_q[gi] | grant[gi];
    assign accept[gi]     = fu_valid_i[gi] & fu_ready_o[gi];

    always_ff @(posedge clock_i) begin
      if (reset_i || squash_i) begin
        slot_valid_q[gi] <= 1'b0;
      end else if (accept[gi]) begin
        slot_valid_q[gi] <= 1'b1;
        slot_pr_q[gi]    <= fu_dest_pr_i[gi*PR_W +: PR_W];
        slot_value_q[gi] <= fu_value_i[gi*XLEN +: XLEN];
        slot_rob_q[gi]   <= fu_rob_entry_i[gi*ROB_W +: ROB_W];
        slot_br_q[gi]    <= fu_take_branch_i[gi];
        slot_tgt_q[gi]   <= fu_target_pc_i[gi*XLEN +: XLEN];
      end else if (grant[gi]) begin
        slot_valid_q[gi] <= 1'b0;
      end
    end
  end

  for (gi = 0; gi < CDB_W; gi++) begin : g_lane
    always_ff @(posedge clock_i) begin
      if (reset_i || squash_i || !lane_act[gi]) begin
        cdb_valid_q[gi] <= 1'b0;
        cdb_pr_q[gi]    <= '0;
        cdb_value_q[gi] <= '0;
        cdb_rob_q[gi]   <= '0;
        cdb_psv_q[gi]   <= 1'b0;
        cdb_tgt_q[gi]   <= '0;
      end else begin
        cdb_valid_q[gi] <= 1'b1;
        cdb_pr_q[gi]    <= slot_pr_q[lane_sel[gi]];
        cdb_value_q[gi] <= slot_value_q[lane_sel[gi]];
        cdb_rob_q[gi]   <= slot_rob_q[lane_sel[gi]];
        cdb_psv_q[gi]   <= slot_br_q[lane_sel[gi]];
        cdb_tgt_q[gi]   <= slot_br_q[lane_sel[gi]] ? slot_tgt_q[lane_sel[gi]] : '0;
      end
    end

    assign cdb_valid_o[gi]                     = cdb_valid_q[gi];
    assign cdb_pr_o[gi*PR_W +: PR_W]           = cdb_pr_q[gi];
    assign cdb_value_o[gi*XLEN +: XLEN]        = cdb_value_q[gi];
    assign complete_entry_o[gi*ROB_W +: ROB_W] = cdb_rob_q[gi];
    assign precise_state_valid_o[gi]           = cdb_psv_q[gi];
    assign target_pc_o[gi*XLEN +: XLEN]        = cdb_tgt_q[gi];
  end

endmodule
